// File: rtl/icache_sa_param_if.sv
// icache_sa_param_if
// Bundles the fetch-side request/response signals and the memory-side refill
// handshake of the instruction cache.
//   slave  : cache view (receives fetch requests, issues refill requests)
//   master : environment view (fetch stage plus memory hierarchy)
// Signals:
//   req_valid/req_ready/req_addr    fetch request handshake and byte address
//   rsp_valid/rsp_data              returned cache line
//   mem_req_valid/ready/addr        refill request (line address)
//   mem_rsp_valid/mem_rsp_data      refill data return
interface icache_sa_param_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
);
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);

  logic                        req_valid;
  logic                        req_ready;
  logic [ADDR_WIDTH-1:0]       req_addr;
  logic                        rsp_valid;
  logic [LINE_WIDTH-1:0]       rsp_data;
  logic                        mem_req_valid;
  logic                        mem_req_ready;
  logic [ADDR_WIDTH-OFF_W-1:0] mem_req_addr;
  logic                        mem_rsp_valid;
  logic [LINE_WIDTH-1:0]       mem_rsp_data;

  modport slave (
    input  req_valid, req_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output req_ready, rsp_valid, rsp_data, mem_req_valid, mem_req_addr
  );

  modport master (
    output req_valid, req_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  req_ready, rsp_valid, rsp_data, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/icache_sa_param.sv
// icache_sa_param
// Parametrised set-associative read-only instruction cache. Hits answer in the
// cycle the request is accepted; misses go through MISS_REQ -> MISS_WAIT ->
// FILL and answer in FILL. Replacement takes the lowest invalid way, otherwise
// the per-set round-robin pointer. A flush clears every valid bit; a refill in
// flight when a flush arrives still answers but does not install its line.
// Ports:
//   clock, reset   clock and synchronous active-high reset
//   flush          one-cycle pulse invalidating all lines
//   bus            icache_sa_param_if.slave (fetch and refill handshakes)
//   hit_count      saturating count of hits
//   miss_count     saturating count of misses
module icache_sa_param #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int NUM_SETS   = 4,
  parameter int NUM_WAYS   = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  icache_sa_param_if.slave      bus,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_WIDTH - OFF_W - SET_W;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int LA_W  = ADDR_WIDTH - OFF_W;

  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT, FILL} state_t;
  state_t state, state_next;

  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]      rr_ptr  [NUM_SETS];

  logic [SET_W-1:0]      miss_set;
  logic [TAG_W-1:0]      miss_tag;
  logic [LA_W-1:0]       miss_line;
  logic [WAY_W-1:0]      victim;
  logic                  victim_valid;
  logic [LINE_WIDTH-1:0] fill_data;
  logic                  flush_pending;

  logic [SET_W-1:0]      req_set;
  logic [TAG_W-1:0]      req_tag;
  logic [NUM_WAYS-1:0]   hit_vec;
  logic                  hit;
  logic [LINE_WIDTH-1:0] hit_line;
  logic [WAY_W-1:0]      pick_way;
  logic                  pick_valid;
  logic                  ready;
  logic                  accept;
  logic                  install;

  assign req_set = bus.req_addr[OFF_W +: SET_W];
  assign req_tag = bus.req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign ready   = (state == IDLE) && !flush && !reset;
  assign accept  = bus.req_valid && ready;
  assign hit     = |hit_vec;
  // A flush seen during the refill or in the FILL cycle itself drops the line.
  assign install = (state == FILL) && !flush_pending && !flush;

  // Tag compare across the indexed set; hit_vec is one-hot so OR-ing is a mux.
  always_comb begin
    hit_vec  = '0;
    hit_line = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_vec[w] = valid_q[req_set][w] && (tag_q[req_set][w] == req_tag);
      if (hit_vec[w]) hit_line = hit_line | data_q[req_set][w];
    end
  end

  // Descending scan so the lowest-index invalid way is the last one written.
  always_comb begin
    pick_way   = rr_ptr[req_set];
    pick_valid = 1'b1;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_set][w]) begin
        pick_way   = WAY_W'(w);
        pick_valid = 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept && !hit)    state_next = MISS_REQ;
      MISS_REQ:  if (bus.mem_req_ready) state_next = MISS_WAIT;
      MISS_WAIT: if (bus.mem_rsp_valid) state_next = FILL;
      FILL:                             state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  // Output logic; every response output is forced low while reset is high.
  always_comb begin
    bus.req_ready     = ready;
    bus.rsp_valid     = 1'b0;
    bus.rsp_data      = '0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_addr  = miss_line;
    if (!reset) begin
      if (state == IDLE && accept && hit) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = hit_line;
      end else if (state == FILL) begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = fill_data;
      end
      bus.mem_req_valid = (state == MISS_REQ);
    end
  end

  // Control state: valid bits, replacement pointers, miss context, counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        rr_ptr[s]  <= '0;
      end
      flush_pending <= 1'b0;
      hit_count     <= '0;
      miss_count    <= '0;
      miss_set      <= '0;
      miss_tag      <= '0;
      miss_line     <= '0;
      victim        <= '0;
      victim_valid  <= 1'b0;
      fill_data     <= '0;
    end else begin
      if (accept && hit && hit_count != '1) hit_count <= hit_count + 32'd1;
      if (accept && !hit) begin
        miss_set     <= req_set;
        miss_tag     <= req_tag;
        miss_line    <= bus.req_addr[ADDR_WIDTH-1:OFF_W];
        victim       <= pick_way;
        victim_valid <= pick_valid;
        if (miss_count != '1) miss_count <= miss_count + 32'd1;
      end
      if (state == MISS_WAIT && bus.mem_rsp_valid) fill_data <= bus.mem_rsp_data;
      if (install) begin
        valid_q[miss_set][victim] <= 1'b1;
        // Pointer only advances when a live line was actually evicted.
        if (victim_valid)
          rr_ptr[miss_set] <= (victim == WAY_W'(NUM_WAYS - 1)) ? '0 : victim + 1'b1;
      end
      if (state == FILL) flush_pending <= 1'b0;
      if (flush && (state == MISS_REQ || state == MISS_WAIT)) flush_pending <= 1'b1;
      // Placed last so a flush overrides any valid bit set above.
      if (flush) begin
        for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
      end
    end
  end

  // Line storage; contents are only meaningful behind a valid bit.
  always_ff @(posedge clock) begin
    if (install) begin
      tag_q[miss_set][victim]  <= miss_tag;
      data_q[miss_set][victim] <= fill_data;
    end
  end

  a_single_hit: assert property (@(posedge clock) disable iff (reset) accept |-> $onehot0(hit_vec));
endmodule

// File: tb/tb_icache_sa_param.sv
// tb_icache_sa_param
// Drives two cache instances (default geometry, and 8 sets x 4 ways x 256-bit
// lines) through one shared stimulus path selected by 'sel', and checks them
// against a set/way reference model computed from address arithmetic.
`timescale 1ns/1ps
module tb_icache_sa_param;
  logic clock;
  logic reset;
  logic flush;
  logic sel;
  logic req_valid;
  logic [31:0]  req_addr;
  logic mem_req_ready;
  logic mem_rsp_valid;
  logic [255:0] mem_rsp_data;
  logic [31:0]  hit_a, miss_a, hit_b, miss_b;

  logic         o_req_ready, o_rsp_valid, o_mem_req_valid;
  logic [255:0] o_rsp_data;
  logic [31:0]  o_mem_addr, o_hit, o_miss;

  int n_sets, n_ways, line_bytes;
  bit           m_valid [8][4];
  int unsigned  m_tag   [8][4];
  logic [255:0] m_data  [8][4];
  int           m_rr    [8];
  int unsigned  m_hits, m_misses;
  int total, bad;

  icache_sa_param_if #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) bus_a ();
  icache_sa_param_if #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) bus_b ();

  assign bus_a.req_valid     = req_valid && !sel;
  assign bus_a.req_addr      = req_addr;
  assign bus_a.mem_req_ready = mem_req_ready && !sel;
  assign bus_a.mem_rsp_valid = mem_rsp_valid && !sel;
  assign bus_a.mem_rsp_data  = mem_rsp_data[127:0];
  assign bus_b.req_valid     = req_valid && sel;
  assign bus_b.req_addr      = req_addr;
  assign bus_b.mem_req_ready = mem_req_ready && sel;
  assign bus_b.mem_rsp_valid = mem_rsp_valid && sel;
  assign bus_b.mem_rsp_data  = mem_rsp_data;

  icache_sa_param #(.ADDR_WIDTH(32), .LINE_WIDTH(128), .NUM_SETS(4), .NUM_WAYS(2)) dut_a (
    .clock(clock), .reset(reset), .flush(flush && !sel), .bus(bus_a),
    .hit_count(hit_a), .miss_count(miss_a));

  icache_sa_param #(.ADDR_WIDTH(32), .LINE_WIDTH(256), .NUM_SETS(8), .NUM_WAYS(4)) dut_b (
    .clock(clock), .reset(reset), .flush(flush && sel), .bus(bus_b),
    .hit_count(hit_b), .miss_count(miss_b));

  assign o_req_ready     = sel ? bus_b.req_ready     : bus_a.req_ready;
  assign o_rsp_valid     = sel ? bus_b.rsp_valid     : bus_a.rsp_valid;
  assign o_rsp_data      = sel ? bus_b.rsp_data      : {128'b0, bus_a.rsp_data};
  assign o_mem_req_valid = sel ? bus_b.mem_req_valid : bus_a.mem_req_valid;
  assign o_mem_addr      = sel ? 32'(bus_b.mem_req_addr) : 32'(bus_a.mem_req_addr);
  assign o_hit           = sel ? hit_b  : hit_a;
  assign o_miss          = sel ? miss_b : miss_a;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory contents are a fixed function of the line address.
  function automatic logic [255:0] mem_line(input int unsigned la);
    logic [255:0] v;
    for (int k = 0; k < 8; k++)
      v[k*32 +: 32] = (la * 32'h9E3779B1) ^ (32'(k) * 32'h01010101) ^ 32'h5A5A0000;
    return v;
  endfunction

  function automatic logic [255:0] exp_line(input int unsigned la);
    logic [255:0] v;
    v = mem_line(la);
    if (line_bytes == 16) v[255:128] = '0;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic checkCounters();
    checkOutput("hit_count", o_hit, m_hits);
    checkOutput("miss_count", o_miss, m_misses);
  endtask

  task automatic modelClear(input bit counters);
    for (int s = 0; s < 8; s++) begin
      for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
      if (counters) m_rr[s] = 0;
    end
    if (counters) begin
      m_hits = 0;
      m_misses = 0;
    end
  endtask

  // Holds reset for one cycle with a live request on the bus.
  task automatic resetDut();
    @(negedge clock);
    reset = 1'b1; req_valid = 1'b1; req_addr = 32'h100;
    mem_req_ready = 1'b0; flush = 1'b0;
    #1;
    checkOutput("rst_req_ready", o_req_ready, 0);
    checkOutput("rst_rsp_valid", o_rsp_valid, 0);
    checkOutput("rst_mem_req_valid", o_mem_req_valid, 0);
    checkOutput("rst_rsp_data", o_rsp_data, 0);
    @(negedge clock);
    reset = 1'b0; req_valid = 1'b0; mem_rsp_valid = 1'b0;
    modelClear(1'b1);
    #1;
    checkOutput("post_rst_req_ready", o_req_ready, 1);
    checkCounters();
  endtask

  task automatic useConfig(input bit b);
    sel = b;
    if (b) begin n_sets = 8; n_ways = 4; line_bytes = 32; end
    else   begin n_sets = 4; n_ways = 2; line_bytes = 16; end
    resetDut();
  endtask

  task automatic flushIdle(input logic [31:0] addr);
    @(negedge clock);
    flush = 1'b1; req_valid = 1'b1; req_addr = addr;
    #1;
    checkOutput("flush_req_ready", o_req_ready, 0);
    checkOutput("flush_rsp_valid", o_rsp_valid, 0);
    @(negedge clock);
    flush = 1'b0; req_valid = 1'b0;
    modelClear(1'b0);
    #1;
    checkCounters();
  endtask

  // fmode: 0 none, 1 flush in first MISS_WAIT cycle, 2 flush in FILL.
  // abort: reset in MISS_WAIT followed by a stray refill response.
  task automatic applyStimulus(input logic [31:0] addr, input int rdy_delay,
                               input int rsp_delay, input int fmode, input bit abort);
    int unsigned la, s, t;
    int hw, vic;
    bit vic_valid;
    logic [255:0] line;
    la = addr / line_bytes;
    s  = la % n_sets;
    t  = la / n_sets;
    line = exp_line(la);
    hw = -1;
    for (int w = 0; w < n_ways; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) hw = w;

    @(negedge clock);
    req_valid = 1'b1; req_addr = addr;
    #1;
    checkOutput("req_ready", o_req_ready, 1);
    if (hw >= 0) begin
      checkOutput("hit_rsp_valid", o_rsp_valid, 1);
      checkOutput("hit_rsp_data", o_rsp_data, m_data[s][hw]);
      checkOutput("hit_mem_req_valid", o_mem_req_valid, 0);
      m_hits++;
      @(negedge clock);
      req_valid = 1'b0;
      #1;
      checkOutput("post_hit_rsp_valid", o_rsp_valid, 0);
      checkCounters();
      return;
    end

    checkOutput("miss_rsp_valid", o_rsp_valid, 0);
    m_misses++;
    vic = -1;
    for (int w = n_ways - 1; w >= 0; w--) if (!m_valid[s][w]) vic = w;
    vic_valid = (vic < 0);
    if (vic < 0) vic = m_rr[s];

    @(negedge clock);
    req_valid = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    for (int i = 0; i <= rdy_delay; i++) begin
      if (i == rdy_delay) mem_req_ready = 1'b1;
      #1;
      checkOutput("mreq_valid", o_mem_req_valid, 1);
      checkOutput("mreq_addr", o_mem_addr, la);
      checkOutput("mreq_req_ready", o_req_ready, 0);
      checkOutput("mreq_rsp_valid", o_rsp_valid, 0);
      @(negedge clock);
    end
    mem_req_ready = 1'b0;

    if (abort) begin
      req_valid = 1'b0;
      reset = 1'b1;
      #1;
      checkOutput("abort_rst_rsp_valid", o_rsp_valid, 0);
      checkOutput("abort_rst_req_ready", o_req_ready, 0);
      @(negedge clock);
      reset = 1'b0;
      modelClear(1'b1);
      mem_rsp_valid = 1'b1; mem_rsp_data = mem_line(la);
      #1;
      checkOutput("stray_rsp_valid", o_rsp_valid, 0);
      checkOutput("stray_req_ready", o_req_ready, 1);
      @(negedge clock);
      mem_rsp_valid = 1'b0;
      #1;
      checkOutput("stray_post_rsp_valid", o_rsp_valid, 0);
      checkOutput("stray_post_mem_req_valid", o_mem_req_valid, 0);
      checkCounters();
      return;
    end

    for (int i = 0; i <= rsp_delay; i++) begin
      if (i == rsp_delay) begin
        mem_rsp_valid = 1'b1; mem_rsp_data = mem_line(la);
      end
      if (fmode == 1 && i == 0) flush = 1'b1;
      #1;
      checkOutput("wait_mem_req_valid", o_mem_req_valid, 0);
      checkOutput("wait_rsp_valid", o_rsp_valid, 0);
      checkOutput("wait_rsp_data", o_rsp_data, 0);
      checkOutput("wait_req_ready", o_req_ready, 0);
      @(negedge clock);
      flush = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = {8{$urandom}};
      if (i == rsp_delay) req_valid = 1'b0;
    end
    if (fmode == 1) modelClear(1'b0);

    if (fmode == 2) flush = 1'b1;
    #1;
    checkOutput("fill_rsp_valid", o_rsp_valid, 1);
    checkOutput("fill_rsp_data", o_rsp_data, line);
    checkOutput("fill_req_ready", o_req_ready, 0);
    @(negedge clock);
    flush = 1'b0;
    if (fmode == 0) begin
      m_valid[s][vic] = 1'b1;
      m_tag[s][vic]   = t;
      m_data[s][vic]  = line;
      if (vic_valid) m_rr[s] = (vic + 1) % n_ways;
    end else if (fmode == 2) begin
      modelClear(1'b0);
    end
    #1;
    checkOutput("idle_rsp_valid", o_rsp_valid, 0);
    checkOutput("idle_rsp_data", o_rsp_data, 0);
    checkOutput("idle_req_ready", o_req_ready, 1);
    checkCounters();
  endtask

  task automatic randomRun(input int n);
    logic [31:0] a;
    int r;
    for (int k = 0; k < n; k++) begin
      a = 32'($urandom_range(0, n_sets * line_bytes * 6 - 1)) & ~32'h3;
      r = $urandom_range(0, 29);
      if (r == 0) flushIdle(a);
      else applyStimulus(a, $urandom_range(0, 3), $urandom_range(0, 3),
                         (r < 3) ? 1 : ((r < 5) ? 2 : 0), r == 5);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; flush = 1'b0; sel = 1'b0;
    req_valid = 1'b0; req_addr = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;

    // Basic miss then same-line hit.
    useConfig(1'b0);
    applyStimulus(32'h100, 0, 2, 0, 0);
    applyStimulus(32'h104, 0, 0, 0, 0);
    checkOutput("basic_hits", o_hit, 1);
    checkOutput("basic_misses", o_miss, 1);
    applyStimulus(32'h200, 5, 1, 0, 0);

    // Set-0 conflicts: third fill evicts way 0.
    useConfig(1'b0);
    applyStimulus(32'h000, 0, 0, 0, 0);
    applyStimulus(32'h040, 1, 0, 0, 0);
    applyStimulus(32'h080, 0, 1, 0, 0);
    applyStimulus(32'h040, 0, 0, 0, 0);
    applyStimulus(32'h000, 0, 0, 0, 0);
    checkOutput("rr_hits", o_hit, 1);
    checkOutput("rr_misses", o_miss, 4);

    // Flush during the refill, in FILL, and in IDLE; then reset mid-miss.
    useConfig(1'b0);
    applyStimulus(32'h100, 0, 0, 0, 0);
    applyStimulus(32'h300, 0, 2, 1, 0);
    applyStimulus(32'h300, 0, 0, 0, 0);
    applyStimulus(32'h100, 0, 0, 0, 0);
    checkOutput("flush_misses", o_miss, 4);
    applyStimulus(32'h400, 0, 0, 2, 0);
    applyStimulus(32'h400, 0, 0, 0, 0);
    flushIdle(32'h400);
    applyStimulus(32'h500, 1, 0, 0, 1);
    randomRun(150);

    // Wide geometry: four conflicting fills hit, the fifth evicts way 0.
    useConfig(1'b1);
    for (int k = 0; k < 4; k++) applyStimulus(32'(k) * 32'h100, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) applyStimulus(32'(k) * 32'h100 + 32'h8, 0, 0, 0, 0);
    applyStimulus(32'h400, 0, 0, 0, 0);
    applyStimulus(32'h100, 0, 0, 0, 0);
    applyStimulus(32'h000, 0, 0, 0, 0);
    checkOutput("wide_hits", o_hit, 5);
    checkOutput("wide_misses", o_miss, 6);
    randomRun(150);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
